// File: rtl/csr_ctrl.sv
// csr_ctrl: sequences CSR read-modify-write, ECALL and MRET operations
// between the decode stage, the CSR register file and fetch redirect.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid / in_ready        upstream instruction handshake
//   pc, csr_op, csr_addr,
//   rs1_data                   offered instruction fields
//   mepc_rd .. mtvec_rd        current CSR register values
//   csr_pc, ecall_flag, csrd,
//   csr_wen                    CSR register file write controls
//                              (wen [0] mepc, [1] mcause, [2] mstatus, [3] mtvec)
//   out_valid / out_ready,
//   rd_data                    write-back handshake, old CSR value
//   redirect_valid,
//   redirect_pc                fetch redirect for trap / return
//
// Optional feature: CSR_CTRL_ILLEGAL_TRAP_EN turns CSR accesses to unmapped
// addresses into an illegal-instruction trap (extra TRAP2 state).

module csr_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] pc,
    input  logic [2:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] mepc_rd,
    input  logic [31:0] mcause_rd,
    input  logic [31:0] mstatus_rd,
    input  logic [31:0] mtvec_rd,
    output logic [31:0] csr_pc,
    output logic        ecall_flag,
    output logic [31:0] csrd,
    output logic [3:0]  csr_wen,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] rd_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned WEN_W  = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
`ifdef CSR_CTRL_ILLEGAL_TRAP_EN
    localparam logic [1:0] TRAP2 = 2'd3;
`endif

    localparam logic [OP_W-1:0] OP_RW    = 3'b001;
    localparam logic [OP_W-1:0] OP_RS    = 3'b010;
    localparam logic [OP_W-1:0] OP_RC    = 3'b011;
    localparam logic [OP_W-1:0] OP_ECALL = 3'b100;
    localparam logic [OP_W-1:0] OP_MRET  = 3'b101;

    logic [1:0]        state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] csrd_q, csrd_d;
    logic [DATA_W-1:0] csr_pc_q, csr_pc_d;
    logic [DATA_W-1:0] redir_pc_q, redir_pc_d;
    logic [WEN_W-1:0]  wen_q, wen_d;
    logic              ecall_q, ecall_d;
    logic              redir_q, redir_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
`ifdef CSR_CTRL_ILLEGAL_TRAP_EN
    logic              trap_q, trap_d;
`endif

    // Live address decode of the offered instruction
    logic              mapped_c;
    logic              is_rw_c;
    logic [DATA_W-1:0] old_c;
    logic [WEN_W-1:0]  wen_sel_c;

    always_comb begin
        mapped_c  = 1'b1;
        old_c     = '0;
        wen_sel_c = '0;
        case (csr_addr)
            12'h341: begin old_c = mepc_rd;    wen_sel_c = 4'b0001; end
            12'h342: begin old_c = mcause_rd;  wen_sel_c = 4'b0010; end
            12'h300: begin old_c = mstatus_rd; wen_sel_c = 4'b0100; end
            12'h305: begin old_c = mtvec_rd;   wen_sel_c = 4'b1000; end
            default: mapped_c = 1'b0;
        endcase
        is_rw_c = (csr_op == OP_RW) || (csr_op == OP_RS) || (csr_op == OP_RC);
    end

    // Next state plus next value of every registered output
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_data_d  = rd_data_q;
        csrd_d     = '0;
        csr_pc_d   = '0;
        redir_pc_d = '0;
        wen_d      = '0;
        ecall_d    = 1'b0;
        redir_d    = 1'b0;
`ifdef CSR_CTRL_ILLEGAL_TRAP_EN
        trap_d     = trap_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = EXEC;
                    op_d      = csr_op;
                    rd_data_d = is_rw_c ? old_c : '0;
`ifdef CSR_CTRL_ILLEGAL_TRAP_EN
                    trap_d    = is_rw_c && !mapped_c;
`endif
                    // EXEC-cycle outputs are prepared here so they appear registered
                    if (is_rw_c && mapped_c) begin
                        wen_d = wen_sel_c;
                        case (csr_op)
                            OP_RS:   csrd_d = old_c | rs1_data;
                            OP_RC:   csrd_d = old_c & ~rs1_data;
                            default: csrd_d = rs1_data;
                        endcase
                    end
`ifdef CSR_CTRL_ILLEGAL_TRAP_EN
                    else if (is_rw_c) begin
                        csrd_d = pc;
                        wen_d  = 4'b0001;
                    end
`endif
                    if (csr_op == OP_ECALL) begin
                        ecall_d    = 1'b1;
                        csr_pc_d   = pc;
                        redir_d    = 1'b1;
                        redir_pc_d = mtvec_rd;
                    end else if (csr_op == OP_MRET) begin
                        redir_d    = 1'b1;
                        redir_pc_d = mepc_rd;
                    end
                end
            end
            EXEC: begin
                if (op_q == OP_ECALL || op_q == OP_MRET) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
`ifdef CSR_CTRL_ILLEGAL_TRAP_EN
                // Second trap cycle: record cause 2 (illegal instruction)
                if (trap_q) begin
                    state_d    = TRAP2;
                    csrd_d     = DATA_W'(2);
                    wen_d      = 4'b0010;
                    redir_d    = 1'b1;
                    redir_pc_d = mtvec_rd;
                end
`endif
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef CSR_CTRL_ILLEGAL_TRAP_EN
            TRAP2: begin
                state_d = IDLE;
                trap_d  = 1'b0;
            end
`endif
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == RESP);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rd_data_q   <= '0;
            csrd_q      <= '0;
            csr_pc_q    <= '0;
            redir_pc_q  <= '0;
            wen_q       <= '0;
            ecall_q     <= 1'b0;
            redir_q     <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef CSR_CTRL_ILLEGAL_TRAP_EN
            trap_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_data_q   <= rd_data_d;
            csrd_q      <= csrd_d;
            csr_pc_q    <= csr_pc_d;
            redir_pc_q  <= redir_pc_d;
            wen_q       <= wen_d;
            ecall_q     <= ecall_d;
            redir_q     <= redir_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef CSR_CTRL_ILLEGAL_TRAP_EN
            trap_q      <= trap_d;
`endif
        end
    end

    // Side-effecting strobes are masked while reset is asserted
    assign csr_wen        = wen_q & {WEN_W{rst_n}};
    assign ecall_flag     = ecall_q & rst_n;
    assign redirect_valid = redir_q & rst_n;
    assign out_valid      = out_valid_q & rst_n;

    assign in_ready    = in_ready_q;
    assign csrd        = csrd_q;
    assign csr_pc      = csr_pc_q;
    assign rd_data     = rd_data_q;
    assign redirect_pc = redir_pc_q;

endmodule

// File: tb/tb_csr_ctrl.sv
module tb_csr_ctrl;

`ifdef CSR_CTRL_ILLEGAL_TRAP_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [31:0] mepc_rd, mcause_rd, mstatus_rd, mtvec_rd;
    logic [31:0] csr_pc;
    logic        ecall_flag;
    logic [31:0] csrd;
    logic [3:0]  csr_wen;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rd_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference view of the CSR file: address -> value and address -> wen bit
    logic [31:0] csr_file [logic [11:0]];
    int          wen_bit  [logic [11:0]];

    always #5 clk = ~clk;

    csr_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .csr_op(csr_op), .csr_addr(csr_addr), .rs1_data(rs1_data),
        .mepc_rd(mepc_rd), .mcause_rd(mcause_rd), .mstatus_rd(mstatus_rd),
        .mtvec_rd(mtvec_rd), .csr_pc(csr_pc), .ecall_flag(ecall_flag),
        .csrd(csrd), .csr_wen(csr_wen), .out_valid(out_valid),
        .out_ready(out_ready), .rd_data(rd_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_csrs(input logic [31:0] m_epc, input logic [31:0] m_cause,
                            input logic [31:0] m_status, input logic [31:0] m_tvec);
        mepc_rd = m_epc; mcause_rd = m_cause; mstatus_rd = m_status; mtvec_rd = m_tvec;
        csr_file[12'h341] = m_epc;
        csr_file[12'h342] = m_cause;
        csr_file[12'h300] = m_status;
        csr_file[12'h305] = m_tvec;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".in_ready"},  32'(in_ready), 32'd1);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".wen"},       32'(csr_wen), 32'd0);
        chk({tag, ".redirect"},  32'(redirect_valid), 32'd0);
        chk({tag, ".ecall"},     32'(ecall_flag), 32'd0);
    endtask

    // One complete transaction, expectations derived from the instruction rules
    task automatic run_txn(input string tag, input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] p, input logic [31:0] rs1, input int stall);
        bit          is_rw, mapped, trap, redir, resp;
        logic [31:0] old_v, new_v, exp_rpc, exp_rd, exp_csrd;
        logic [3:0]  exp_wen;

        is_rw  = (op >= 3'd1 && op <= 3'd3);
        mapped = csr_file.exists(addr);
        old_v  = mapped ? csr_file[addr] : 32'd0;
        case (op)
            3'd1:    new_v = rs1;
            3'd2:    new_v = old_v | rs1;
            default: new_v = old_v & ~rs1;
        endcase
        trap     = ILL_EN && is_rw && !mapped;
        exp_wen  = (is_rw && mapped) ? 4'(1 << wen_bit[addr]) : (trap ? 4'b0001 : 4'b0000);
        exp_csrd = trap ? p : new_v;
        redir    = (op == 3'd4) || (op == 3'd5);
        exp_rpc  = (op == 3'd4) ? mtvec_rd : mepc_rd;
        resp     = !redir && !trap;
        exp_rd   = is_rw ? old_v : 32'd0;

        chk({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
        csr_op = op; csr_addr = addr; pc = p; rs1_data = rs1; in_valid = 1'b1;
        tick();
        // Scramble the offer so the DUT must rely on what it latched
        in_valid = 1'b0;
        csr_op = 3'($urandom); csr_addr = 12'($urandom); pc = $urandom; rs1_data = $urandom;

        chk({tag, ".exec_wen"},   32'(csr_wen), 32'(exp_wen));
        if (exp_wen != 4'd0) chk({tag, ".exec_csrd"}, csrd, exp_csrd);
        chk({tag, ".exec_ecall"}, 32'(ecall_flag), 32'(op == 3'd4));
        if (op == 3'd4) chk({tag, ".exec_csr_pc"}, csr_pc, p);
        chk({tag, ".exec_redir"}, 32'(redirect_valid), 32'(redir));
        if (redir) chk({tag, ".exec_rpc"}, redirect_pc, exp_rpc);
        chk({tag, ".exec_ovalid"}, 32'(out_valid), 32'd0);
        chk({tag, ".exec_ready"},  32'(in_ready), 32'd0);
        tick();

        if (trap) begin
            chk({tag, ".trap_wen"},   32'(csr_wen), 32'b0010);
            chk({tag, ".trap_csrd"},  csrd, 32'd2);
            chk({tag, ".trap_redir"}, 32'(redirect_valid), 32'd1);
            chk({tag, ".trap_rpc"},   redirect_pc, mtvec_rd);
            chk({tag, ".trap_ecall"}, 32'(ecall_flag), 32'd0);
            chk({tag, ".trap_ovalid"}, 32'(out_valid), 32'd0);
            tick();
        end

        if (resp) begin
            for (int i = 0; i < stall; i++) begin
                chk({tag, ".stall_ovalid"}, 32'(out_valid), 32'd1);
                chk({tag, ".stall_rd"},     rd_data, exp_rd);
                chk({tag, ".stall_ready"},  32'(in_ready), 32'd0);
                chk({tag, ".stall_wen"},    32'(csr_wen), 32'd0);
                in_valid = 1'b1;  // must be ignored outside IDLE
                tick();
            end
            in_valid = 1'b0;
            chk({tag, ".resp_ovalid"}, 32'(out_valid), 32'd1);
            chk({tag, ".resp_rd"},     rd_data, exp_rd);
            chk({tag, ".resp_redir"},  32'(redirect_valid), 32'd0);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk_quiet({tag, ".after"});
    endtask

    initial begin
        wen_bit[12'h341] = 0;
        wen_bit[12'h342] = 1;
        wen_bit[12'h300] = 2;
        wen_bit[12'h305] = 3;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pc = '0; csr_op = '0; csr_addr = '0; rs1_data = '0;
        set_csrs(32'h0, 32'h0, 32'h0, 32'h0);

        // Reset values
        tick(); tick();
        chk_quiet("rst");
        chk("rst.csrd",  csrd, 32'd0);
        chk("rst.cpc",   csr_pc, 32'd0);
        chk("rst.rd",    rd_data, 32'd0);
        chk("rst.rpc",   redirect_pc, 32'd0);
        rst_n = 1'b1;
        tick();
        chk_quiet("rst_rel");

        set_csrs(32'h8000_0004, 32'h0000_000B, 32'h0000_1800, 32'h8000_0100);
        run_txn("csrrs",  3'd2, 12'h300, 32'h8000_0000, 32'h0000_0008, 1);
        run_txn("ecall",  3'd4, 12'h000, 32'h8000_0010, 32'h0, 0);
        run_txn("bp",     3'd1, 12'h341, 32'h8000_0020, 32'hDEAD_BEEF, 5);
        set_csrs(32'h8000_0014, 32'h0000_000B, 32'h0000_1800, 32'h8000_0100);
        run_txn("mret",   3'd5, 12'h000, 32'h8000_0030, 32'h0, 0);
        run_txn("unmap",  3'd1, 12'h7C0, 32'h8000_0040, 32'h1234_5678, 2);
        run_txn("csrrc",  3'd3, 12'h342, 32'h8000_0050, 32'h0000_0003, 0);
        run_txn("mtvec",  3'd1, 12'h305, 32'h8000_0054, 32'h8000_0200, 0);
        run_txn("nop0",   3'd0, 12'h341, 32'h8000_0060, 32'hFFFF_FFFF, 1);
        run_txn("nop7",   3'd7, 12'h300, 32'h8000_0064, 32'hFFFF_FFFF, 0);

        // Reset while holding a response
        csr_op = 3'd1; csr_addr = 12'h341; pc = 32'h8000_0070; rs1_data = 32'h5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rresp.ovalid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rresp.gate_ovalid", 32'(out_valid), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        chk_quiet("rresp.post");
        tick();
        chk_quiet("rresp.post2");

        // Reset during an ECALL's redirect cycle
        csr_op = 3'd4; csr_addr = 12'h0; pc = 32'h8000_0080; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rexec.redir", 32'(redirect_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rexec.gate_redir", 32'(redirect_valid), 32'd0);
        chk("rexec.gate_ecall", 32'(ecall_flag), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_quiet("rexec.post");

        // Randomized transactions
        for (int t = 0; t < 200; t++) begin
            logic [11:0] a;
            set_csrs($urandom, $urandom, $urandom, $urandom);
            case ($urandom_range(0, 4))
                0:       a = 12'h341;
                1:       a = 12'h342;
                2:       a = 12'h300;
                3:       a = 12'h305;
                default: a = 12'($urandom);
            endcase
            run_txn("rnd", 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                    int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_ctrl.md
CSR_CTRL -- requirements
Module: csr_ctrl

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 in_valid  in  1 / in_ready  out  1  upstream (decode) handshake; transfer when both high at a clock edge.
REQ-004 pc  in  32  PC of the offered instruction.
REQ-005 csr_op  in  3  operation code: 001 CSRRW, 010 CSRRS, 011 CSRRC, 100 ECALL, 101 MRET, others NOP.
REQ-006 csr_addr  in  12  CSR address / rs1_data  in  32  source operand.
REQ-007 mepc_rd, mcause_rd, mstatus_rd, mtvec_rd  in  32 each  current CSR register values.
REQ-008 csr_pc  out  32 / ecall_flag  out  1 / csrd  out  32 / csr_wen  out  4  drive the CSR register file; wen bits: [0] mepc, [1] mcause, [2] mstatus, [3] mtvec.
REQ-009 out_valid  out  1 / out_ready  in  1 / rd_data  out  32  write-back handshake carrying the old CSR value.
REQ-010 redirect_valid  out  1 / redirect_pc  out  32  fetch redirect for a trap or return.

Function
REQ-011 Address map SHALL be:
- 0x341 mepc
- 0x342 mcause
- 0x300 mstatus
- 0x305 mtvec
- any other address is unmapped.
REQ-012 FSM states SHALL be IDLE, EXEC, RESP, TRAP2. in_ready=1 only in IDLE.
REQ-013 On acceptance, SHALL latch op, addr, pc, rs1_data and the old value of the addressed CSR (0 if unmapped); next state EXEC.
REQ-014 EXEC, CSRRW/RS/RC, one cycle:
- csrd = rs1 (RW), old|rs1 (RS), old&~rs1 (RC)
- the mapped wen bit is asserted for exactly this cycle
- next state RESP.
REQ-015 RESP: out_valid=1 with rd_data=latched old value, held stable until out_ready; on handshake, next state IDLE. Earliest out_valid is 2 cycles after acceptance.
REQ-016 EXEC, ECALL:
- ecall_flag=1 and csr_pc=latched pc for one cycle
- redirect_valid=1, redirect_pc=mtvec_rd for the same cycle
- no out_valid; next state IDLE.
REQ-017 EXEC, MRET: redirect_valid=1, redirect_pc=mepc_rd for one cycle; no CSR write; next state IDLE.
REQ-018 NOP op: no write, no redirect; RESP with rd_data=0.
REQ-019 Unmapped address (macro off): reads 0, csr_wen stays 0000, normal RESP.
REQ-020 csr_wen SHALL be one-hot or zero. ecall_flag and any csr_wen bit SHALL never be high in the same cycle.
REQ-021 When out_ready is held low, the FSM SHALL stay in RESP indefinitely with outputs unchanged. in_valid is ignored outside IDLE.

Reset
REQ-022 rst_n low at an edge SHALL force IDLE from any state, abandoning any in-flight operation. No response or redirect is emitted afterwards.
REQ-023 Reset values:
- in_ready=1 after reset
- out_valid=0, redirect_valid=0, ecall_flag=0, csr_wen=0, csrd=0, csr_pc=0, rd_data=0, redirect_pc=0.
REQ-024 csr_wen, ecall_flag, redirect_valid and out_valid SHALL be gated to 0 in any cycle where rst_n is low.

Configuration
REQ-025 Macro CSR_CTRL_ILLEGAL_TRAP_EN defined: unmapped addresses with op RW/RS/RC SHALL raise an illegal-instruction trap instead of REQ-019:
- EXEC: csrd=pc, csr_wen=0001
- TRAP2: csrd=2, csr_wen=0010, redirect_valid=1, redirect_pc=mtvec_rd
- then IDLE, no out_valid.
REQ-026 Macro undefined: TRAP2 SHALL not exist and REQ-019 applies.

Verification
REQ-027 Reset: hold rst_n=0 for 2 cycles while in RESP -> next cycle in_ready=1, out_valid=0, csr_wen=0000.
REQ-028 CSRRS: addr 0x300, mstatus_rd=0x1800, rs1=0x8 ->
- EXEC: csrd=0x1808, csr_wen=0100
- RESP: rd_data=0x1800.
REQ-029 ECALL: pc=0x80000010, mtvec_rd=0x80000100 -> one-cycle ecall_flag=1, csr_pc=0x80000010, redirect_pc=0x80000100; no out_valid.
REQ-030 Back-pressure: CSRRW to 0x341, out_ready=0 for 5 cycles -> out_valid stays 1, rd_data stable, in_ready=0; completes on out_ready=1.
REQ-031 MRET: mepc_rd=0x80000014 -> redirect_valid pulse with redirect_pc=0x80000014, csr_wen=0000.
REQ-032 Unmapped address 0x7C0, CSRRW:
- macro off: rd_data=0, no writes
- macro on: csr_wen sequence 0001 then 0010, csrd=pc then 2, redirect to mtvec_rd.
